// File: rtl/seq_encoder_16x4.sv
// Sequential 16-to-4 encoder: emits the index of every set bit of a captured vector, one per handshake.
// Define ENC_MSB_FIRST_EN to scan from bit 15 downward instead of from bit 0 upward.
module seq_encoder_16x4 #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] idx,
    output logic         last,
    output logic         none,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        ZERO = 2'd3
    } state_t;

`ifdef ENC_MSB_FIRST_EN
    localparam logic [W-1:0] PTR_START = W'(N - 1);
`else
    localparam logic [W-1:0] PTR_START = '0;
`endif

    state_t       state;
    logic [N-1:0] vec;
    logic [W-1:0] ptr;

    // True when some set bit of v lies after position p in scan order.
    function automatic logic more_ahead(input logic [N-1:0] v, input logic [W-1:0] p);
        logic found;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
`ifdef ENC_MSB_FIRST_EN
            if ((i < 32'(p)) && v[i]) found = 1'b1;
`else
            if ((i > 32'(p)) && v[i]) found = 1'b1;
`endif
        end
        return found;
    endfunction

    function automatic logic [W-1:0] step(input logic [W-1:0] p);
`ifdef ENC_MSB_FIRST_EN
        return p - W'(1);
`else
        return p + W'(1);
`endif
    endfunction

    // Single-process FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= '0;
            ptr       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            idx       <= '0;
            last      <= 1'b0;
            none      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec      <= din;
                        ptr      <= PTR_START;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (din == '0) ? ZERO : SCAN;
                    end
                end
                SCAN: begin
                    // A set bit is always ahead here, so ptr cannot run off the end.
                    if (vec[ptr]) begin
                        state     <= EMIT;
                        idx       <= ptr;
                        out_valid <= 1'b1;
                        last      <= ~more_ahead(vec, ptr);
                        none      <= 1'b0;
                    end else begin
                        ptr <= step(ptr);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        vec[ptr]  <= 1'b0;
                        out_valid <= 1'b0;
                        if (last) begin
                            state    <= IDLE;
                            last     <= 1'b0;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            ptr   <= step(ptr);
                            state <= SCAN;
                        end
                    end
                end
                ZERO: begin
                    // First cycle raises the response; it then waits for the handshake.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        none      <= 1'b1;
                        last      <= 1'b1;
                        idx       <= '0;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        none      <= 1'b0;
                        last      <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_encoder_16x4.sv
// Directed and randomised self-checking bench for seq_encoder_16x4.
// Build with ENC_MSB_FIRST_EN defined to check the descending scan order.
module tb_seq_encoder_16x4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] din = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  idx;
    logic        last;
    logic        none;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ENC_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    seq_encoder_16x4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idx       (idx),
        .last      (last),
        .none      (none),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // k-th bit position in scan order
    function automatic logic [3:0] pos(input int k);
        return MSB ? 4'(15 - k) : 4'(k);
    endfunction

    // Present a vector for exactly one edge; returns at the negedge after capture.
    task automatic capture(input logic [15:0] v);
        @(negedge clk);
        in_valid = 1'b1;
        din      = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, checking edge count and response fields; passes the handshake edge if out_ready=1.
    task automatic get_resp(input string tag, input int exp_n, input logic [3:0] exp_idx,
                            input logic exp_last, input logic exp_none);
        int n = 0;
        while (!out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".latency"}, 32'(n), 32'(exp_n));
        check_eq({tag, ".idx"},  32'(idx),  32'(exp_idx));
        check_eq({tag, ".last"}, 32'(last), 32'(exp_last));
        check_eq({tag, ".none"}, 32'(none), 32'(exp_none));
        if (out_ready) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check_eq({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] acc;
        logic [3:0]  hold_idx;
        logic        done;
        int          cyc;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        check_eq("reset.idx",  32'(idx),  32'd0);
        check_eq("reset.last", 32'(last), 32'd0);
        check_eq("reset.none", 32'(none), 32'd0);

        // Single bit 0 (LSB) or bit 15 (MSB): both found on the first scan edge
        out_ready = 1'b1;
        capture(MSB ? 16'h8000 : 16'h0001);
        check_eq("single.busy", 32'(busy), 32'd1);
        check_eq("single.in_ready", 32'(in_ready), 32'd0);
        get_resp("single", 1, pos(0), 1'b1, 1'b0);
        check_idle("single.after");

        // Four spread bits; symmetric so gaps are identical in both scan orders
        capture(16'h8421);
        get_resp("v8421.0", 1, MSB ? 4'd15 : 4'd0,  1'b0, 1'b0);
        get_resp("v8421.1", 5, MSB ? 4'd10 : 4'd5,  1'b0, 1'b0);
        get_resp("v8421.2", 5, MSB ? 4'd5  : 4'd10, 1'b0, 1'b0);
        get_resp("v8421.3", 5, MSB ? 4'd0  : 4'd15, 1'b1, 1'b0);
        check_idle("v8421.after");

        // All-zero vector
        capture(16'h0000);
        get_resp("zero", 1, 4'd0, 1'b1, 1'b1);
        check_idle("zero.after");

        // Backpressure holds the response and blocks new input
        out_ready = 1'b0;
        capture(16'h0030);
        get_resp("bp.first", MSB ? 11 : 5, MSB ? 4'd5 : 4'd4, 1'b0, 1'b0);
        hold_idx = MSB ? 4'd5 : 4'd4;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            din      = 16'hFFFF;
            @(negedge clk);
            check_eq("bp.hold_idx",   32'(idx),       32'(hold_idx));
            check_eq("bp.hold_valid", 32'(out_valid), 32'd1);
            check_eq("bp.in_ready",   32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        get_resp("bp.second", 1, MSB ? 4'd4 : 4'd5, 1'b1, 1'b0);
        check_idle("bp.after");

        // Reset in the middle of an emission, with the 4th bit pending
        capture(16'hFFFF);
        get_resp("rst.b0", 1, pos(0), 1'b0, 1'b0);
        get_resp("rst.b1", 1, pos(1), 1'b0, 1'b0);
        get_resp("rst.b2", 1, pos(2), 1'b0, 1'b0);
        out_ready = 1'b0;
        get_resp("rst.b3", 1, pos(3), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_idle("rst.async");
        check_eq("rst.async.idx", 32'(idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst.released");

        // Random vectors with random backpressure; OR of one-hot indices must rebuild the vector
        for (int t = 0; t < 200; t++) begin
            v = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            out_ready = 1'b0;
            capture(v);
            acc  = '0;
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 400) begin
                out_ready = 1'($urandom);
                if (out_valid && out_ready) begin
                    if (!none) acc = acc | (16'd1 << idx);
                    if (last) done = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
            check_eq("rand.done", 32'(done), 32'd1);
            check_eq("rand.decode", 32'(acc), 32'(v));
            check_eq("rand.busy", 32'(busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
